// File: rtl/led_pio_out_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
interface led_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pio_out.sv
// LED output PIO: DATA register with set/clear strobes, per-bit blink mask and a
// programmable half-period blink engine. Registered readback and LED drive.
module led_pio_out #(
  parameter int          WIDTH      = 10,
  parameter int          PERIOD_W   = 24,
  parameter logic [31:0] RESET_DATA = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  led_pio_out_if.slave    bus,
  output logic [WIDTH-1:0] out_port,
  output logic            blink_phase
);

  localparam logic [2:0] A_DATA = 3'd0, A_MASK = 3'd1, A_PERIOD = 3'd2,
                         A_STATUS = 3'd3, A_SET = 3'd4, A_CLR = 3'd5;
  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

  logic [WIDTH-1:0]    data_q, data_d, mask_q, mask_d, out_q, out_d;
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [31:0]         rd_d;
  logic                wr;
  logic [WIDTH-1:0]    wd_w;
  logic [PERIOD_W-1:0] wd_p;
  wire                 unused_wd = &{1'b0, bus.writedata};

  assign wr   = bus.chipselect & ~bus.write_n;
  assign wd_w = bus.writedata[WIDTH-1:0];
  assign wd_p = bus.writedata[PERIOD_W-1:0];

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr) begin
      case (bus.address)
        A_DATA:   data_d   = wd_w;
        A_MASK:   mask_d   = wd_w;
        A_PERIOD: period_d = wd_p;
        A_SET:    data_d   = data_q | wd_w;
        A_CLR:    data_d   = data_q & ~wd_w;
        default:  ;
      endcase
    end
  end

  // Free-running half-period timer; a PERIOD write restarts it in phase 0.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q - P_ONE;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - P_ONE;
    end
    if (wr && bus.address == A_PERIOD) begin
      cnt_d   = (wd_p == '0) ? '0 : wd_p - P_ONE;
      phase_d = 1'b0;
    end
  end

  assign out_d = data_d & ~(mask_d & {WIDTH{phase_d}});

  // Readback uses the pre-write register values.
  always_comb begin
    rd_d = '0;
    case (bus.address)
      A_DATA:   rd_d[WIDTH-1:0]    = data_q;
      A_MASK:   rd_d[WIDTH-1:0]    = mask_q;
      A_PERIOD: rd_d[PERIOD_W-1:0] = period_q;
      A_STATUS: rd_d[1:0]          = {period_q != '0, phase_q};
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= RESET_DATA[WIDTH-1:0];
      mask_q       <= '0;
      period_q     <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      out_q        <= RESET_DATA[WIDTH-1:0];
      bus.readdata <= '0;
    end else begin
      data_q       <= data_d;
      mask_q       <= mask_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      out_q        <= out_d;
      bus.readdata <= rd_d;
    end
  end

  assign out_port    = out_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_led_pio_out.sv
// Directed bench for led_pio_out: edge-counting reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_led_pio_out;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] out_port;
  logic       blink_phase;

  led_pio_out_if bus ();

  led_pio_out #(.WIDTH(10), .PERIOD_W(24), .RESET_DATA(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .out_port(out_port), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int vecs = 0, miss = 0;
  bit cmp_en = 1'b0;

  // Reference state: phase derived from edges elapsed since the last PERIOD load.
  logic [9:0]  m_data = '0, m_mask = '0;
  logic [23:0] m_period = '0;
  logic        m_phase = 1'b0;
  logic [31:0] m_rd = '0;
  int          m_n = 0, m_k = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    chk(nm, bus.readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    fork
      forever begin : model
        @(posedge clk or posedge reset);
        if (reset) begin
          m_data = '0; m_mask = '0; m_period = '0; m_phase = 1'b0;
          m_rd = '0; m_n = 0; m_k = 0;
        end else begin
          case (bus.address)
            3'd0: m_rd = {22'b0, m_data};
            3'd1: m_rd = {22'b0, m_mask};
            3'd2: m_rd = {8'b0, m_period};
            3'd3: m_rd = {30'b0, m_period != 0, m_phase};
            default: m_rd = '0;
          endcase
          m_n++;
          if (bus.chipselect && !bus.write_n) begin
            case (bus.address)
              3'd0: m_data = bus.writedata[9:0];
              3'd1: m_mask = bus.writedata[9:0];
              3'd2: begin m_period = bus.writedata[23:0]; m_k = m_n; end
              3'd4: m_data = m_data | bus.writedata[9:0];
              3'd5: m_data = m_data & ~bus.writedata[9:0];
              default: ;
            endcase
          end
          m_phase = (m_period == 0) ? 1'b0 : (((m_n - m_k) / int'(m_period)) % 2 == 1);
        end
      end
      forever begin : compare
        @(negedge clk);
        if (cmp_en) begin
          chk("model out_port", {22'b0, out_port}, {22'b0, m_data & ~(m_mask & {10{m_phase}})});
          chk("model blink_phase", {31'b0, blink_phase}, {31'b0, m_phase});
          chk("model readdata", bus.readdata, m_rd);
        end
      end
    join_none

    // Reset
    idle(3);
    @(negedge clk); reset = 1'b0;
    cmp_en = 1'b1;
    chk("reset out_port", {22'b0, out_port}, 32'h0);
    chk("reset readdata", bus.readdata, 32'h0);
    chk("reset phase", {31'b0, blink_phase}, 32'h0);
    rd(3'd3, 32'h0, "reset status");

    // DATA and strobes
    wr(3'd0, 32'h2A5); chk("data write", {22'b0, out_port}, 32'h2A5);
    wr(3'd4, 32'h00A); chk("outset", {22'b0, out_port}, 32'h2AF);
    wr(3'd5, 32'h0A0); chk("outclear", {22'b0, out_port}, 32'h20F);
    rd(3'd0, 32'h20F, "read data");
    rd(3'd4, 32'h0, "read outset");

    // Read during write returns the old value
    @(negedge clk);
    bus.address = 3'd0; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h111;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    chk("read-during-write", bus.readdata, 32'h20F);

    // Blink timing: 4 cycles on, 4 cycles with low nibble off
    wr(3'd0, 32'h3FF);
    wr(3'd1, 32'h00F);
    wr(3'd2, 32'h4);
    for (int i = 0; i < 16; i++) begin
      chk("blink pattern", {22'b0, out_port}, ((i / 4) % 2 == 1) ? 32'h3F0 : 32'h3FF);
      chk("blink phase", {31'b0, blink_phase}, {31'b0, ((i / 4) % 2 == 1)});
      if (i < 15) @(negedge clk);
    end
    @(negedge clk); bus.address = 3'd3;
    @(negedge clk);
    chk("status blinking", {31'b0, bus.readdata == 32'h2 || bus.readdata == 32'h3}, 32'h1);

    // Disable during phase 1
    begin
      int t = 0;
      while (blink_phase !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      chk("wait phase1", {31'b0, blink_phase}, 32'h1);
    end
    wr(3'd2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("disabled out", {22'b0, out_port}, 32'h3FF);
      chk("disabled phase", {31'b0, blink_phase}, 32'h0);
      @(negedge clk);
    end
    wr(3'd2, 32'h1);
    for (int i = 0; i < 6; i++) begin
      chk("period1 phase", {31'b0, blink_phase}, {31'b0, i[0]});
      @(negedge clk);
    end

    // Width masking and reserved address
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h3FF, "data width mask");
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, 32'hFF_FFFF, "period width mask");
    wr(3'd6, 32'h123);
    rd(3'd6, 32'h0, "reserved read");
    rd(3'd1, 32'h00F, "mask after reserved write");
    rd(3'd0, 32'h3FF, "data after reserved write");

    // Mid-run asynchronous reset
    wr(3'd2, 32'h5);
    idle(2);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async reset out", {22'b0, out_port}, 32'h0);
    chk("async reset phase", {31'b0, blink_phase}, 32'h0);
    chk("async reset readdata", bus.readdata, 32'h0);
    idle(2);
    @(negedge clk); reset = 1'b0;
    rd(3'd2, 32'h0, "period after reset");
    idle(10);
    chk("quiet after reset", {22'b0, out_port}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/led_pio_out.md
Name: led_pio_out

Overview:
- Avalon-MM slave output PIO that drives the board LEDs (LEDR[9:0]) from the Nios II.
- It is the write-direction counterpart of the switch-input PIO on the same platform bus.
- Provides a data register, atomic set/clear strobes, and a per-bit hardware blink engine with a programmable half-period, so software can flash LEDs without polling.
- Readback of every state register; output port is registered.

Parameters:
- WIDTH, 10, number of output bits (LEDs); 1..32.
- PERIOD_W, 24, width of the blink half-period counter; 1..32.
- RESET_DATA, 0, reset value of the DATA register (low WIDTH bits used).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select; qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  registered LED drive.
- blink_phase  out  1  current blink phase (debug/status).

Behaviour:
- Register map (wr = chipselect & ~write_n):
  - 0 DATA: r/w, low WIDTH bits.
  - 1 BLINK_MASK: r/w, low WIDTH bits.
  - 2 PERIOD: r/w, low PERIOD_W bits.
  - 3 STATUS: read-only; bit0 = phase, bit1 = (PERIOD != 0); writes ignored.
  - 4 OUTSET: write-only; DATA <= DATA | wd. Reads return 0.
  - 5 OUTCLEAR: write-only; DATA <= DATA & ~wd. Reads return 0.
  - 6, 7: reserved; reads return 0, writes ignored.
- Reset values: DATA = RESET_DATA, BLINK_MASK = 0, PERIOD = 0, counter = 0, phase = 0, readdata = 0, out_port = RESET_DATA[WIDTH-1:0], blink_phase = 0.
- readdata:
  - Updated every clk from the currently addressed register, zero-extended to 32 bits; 1-cycle read latency.
  - A read in the same cycle as a write to that register returns the pre-write value.
- Blink engine:
  - When PERIOD == 0, the counter holds 0 and phase holds 0.
  - Otherwise the counter decrements every clk. When the counter == 0: counter <= PERIOD - 1 and phase toggles. Phase therefore toggles every PERIOD cycles.
  - A write to PERIOD loads counter <= new PERIOD - 1 (0 if the new value is 0) and forces phase <= 0 on that edge. This overrides any terminal-count toggle in the same cycle.
- Output:
  - out_port <= DATA_next & ~(BLINK_MASK_next & {WIDTH{phase_next}}), registered.
  - A write becomes visible on out_port exactly 1 cycle after the write edge.
- Bit semantics:
  - Masked bits with DATA = 1 blink.
  - Masked bits with DATA = 0 stay off.
  - Unmasked bits follow DATA.
- blink_phase equals the phase register.
- Unused writedata bits above WIDTH / PERIOD_W are discarded; reads of those bits return 0.
- Only one write per cycle is possible, so OUTSET and OUTCLEAR never collide.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously). The first counting edge is the first clk after reset deasserts.

Test Plan:
- Reset check: hold reset 3 cycles, release -> out_port = 0x000, readdata = 0, blink_phase = 0. Read address 3 -> 0x0.
- DATA and strobes: write DATA = 0x2A5 -> out_port = 0x2A5 one cycle later. Write OUTSET = 0x00A -> 0x2AF. Write OUTCLEAR = 0x0A0 -> 0x20F. Read addr 0 -> 0x20F. Read addr 4 -> 0.
- Blink timing: DATA = 0x3FF, MASK = 0x00F, PERIOD = 4 -> out_port alternates 0x3FF for 4 cycles and 0x3F0 for 4 cycles. blink_phase toggles every 4 clks. STATUS reads 0x2 or 0x3.
- Period disable and reload: during phase 1, write PERIOD = 0 -> phase = 0 and out_port = 0x3FF next cycle, held. Write PERIOD = 1 -> phase toggles every cycle.
- Width masking: write DATA = 0xFFFFFFFF -> readback 0x3FF. Write to addr 6 -> no register changes, and reading addr 6 -> 0.
- Mid-run reset: assert reset during blinking while the counter is nonzero -> out_port = 0 and phase = 0 in the same cycle. After release, PERIOD reads 0 and nothing blinks.
